// File: rtl/uart_loader.sv
// uart_loader: boot-time program loader between the UART RX FIFO and the
// instruction-memory write port. Holds the core stalled, reads a 4-byte
// little-endian word count N, then N little-endian 32-bit words, writes them
// to word addresses 0..N-1, sends 0xAA (or 0xEE on failure) and releases the
// core.
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte (XOR of all preceding bytes) is
//   popped and verified before the acknowledge.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   uart_empty, uart_in  RX FIFO empty flag and show-ahead head byte
//   uart_rdreq           RX FIFO pop (combinational)
//   uart_out, uart_wrreq TX byte and one-cycle push pulse
//   imem_addr/data/we    instruction-memory write port (one pulse per word)
//   core_run             1 releases the core
//   busy                 loader is consuming the image
//   error                sticky load failure
module uart_loader #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_empty,
    input  logic [7:0]        uart_in,
    output logic              uart_rdreq,
    output logic [7:0]        uart_out,
    output logic              uart_wrreq,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              imem_we,
    output logic              core_run,
    output logic              busy,
    output logic              error
);

    localparam logic [2:0] StHdr  = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StAck  = 3'd2;
    localparam logic [2:0] StRun  = 3'd3;
    localparam logic [2:0] StErr  = 3'd4;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam logic [2:0] StCsum = 3'd5;
    localparam logic [2:0] StDone = StCsum;
`else
    localparam logic [2:0] StDone = StAck;
`endif

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       n_q, n_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        out_q, out_d;
    logic              wrreq_q, wrreq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              we_q, we_d;
    logic              error_q, error_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic        consuming;
    logic        pop;
    logic [31:0] n_full;
    logic [31:0] word_full;
    logic        last_word;

    always_comb begin
        consuming = (state_q == StHdr) || (state_q == StLoad);
`ifdef UART_LOADER_CHECKSUM_EN
        consuming = consuming || (state_q == StCsum);
`endif
    end

    assign pop       = consuming && !uart_empty;
    assign n_full    = {uart_in, n_q[23:0]};
    assign word_full = {uart_in, word_q};
    assign last_word = (32'(idx_q) == (n_q - 32'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        word_d  = word_q;
        idx_d   = idx_q;
        out_d   = out_q;
        wrreq_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        error_d = error_q;
`ifdef UART_LOADER_CHECKSUM_EN
        xor_d   = pop ? (xor_q ^ uart_in) : xor_q;
`endif

        case (state_q)
            StHdr: begin
                if (pop) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    n_d[7:0]   = uart_in;
                        2'd1:    n_d[15:8]  = uart_in;
                        2'd2:    n_d[23:16] = uart_in;
                        default: begin
                            n_d = n_full;
                            if (n_full > MAX_WORDS) begin
                                state_d = StErr;
                            end else if (n_full == 32'd0) begin
                                state_d = StDone;
                            end else begin
                                state_d = StLoad;
                                idx_d   = '0;
                            end
                        end
                    endcase
                end
            end
            StLoad: begin
                if (pop) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    word_d[7:0]   = uart_in;
                        2'd1:    word_d[15:8]  = uart_in;
                        2'd2:    word_d[23:16] = uart_in;
                        default: begin
                            we_d   = 1'b1;
                            data_d = word_full;
                            addr_d = idx_q;
                            idx_d  = idx_q + ADDR_W'(1);
                            if (last_word) begin
                                state_d = StDone;
                            end
                        end
                    endcase
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            StCsum: begin
                // xor_q already holds the XOR of every byte before this one.
                if (pop) begin
                    state_d = (uart_in == xor_q) ? StAck : StErr;
                end
            end
`endif
            StAck: state_d = StRun;
            StRun: state_d = StRun;
            StErr: begin
                // The 0xEE pulse occupies the first ERR cycle; error follows it.
                error_d = 1'b1;
            end
            default: state_d = StHdr;
        endcase

        // The TX pulse is produced on the edge that enters ACK or ERR.
        if (state_d != state_q) begin
            if (state_d == StAck) begin
                wrreq_d = 1'b1;
                out_d   = 8'hAA;
            end else if (state_d == StErr) begin
                wrreq_d = 1'b1;
                out_d   = 8'hEE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHdr;
            cnt_q   <= 2'd0;
            n_q     <= 32'd0;
            word_q  <= 24'd0;
            idx_q   <= '0;
            out_q   <= 8'h00;
            wrreq_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            error_q <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            wrreq_q <= wrreq_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            error_q <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign uart_rdreq = pop;
    assign uart_out   = out_q;
    assign uart_wrreq = wrreq_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign imem_we    = we_q;
    assign core_run   = (state_q == StRun);
    assign busy       = consuming;
    assign error      = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: a byte-count model predicts every
// registered output per cycle; directed images plus literal end-of-test checks.
module tb_uart_loader;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              clk;
    logic              rst;
    logic              uart_empty;
    logic [7:0]        uart_in;
    logic              uart_rdreq;
    logic [7:0]        uart_out;
    logic              uart_wrreq;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_we;
    logic              core_run;
    logic              busy;
    logic              error;

    uart_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_empty (uart_empty),
        .uart_in    (uart_in),
        .uart_rdreq (uart_rdreq),
        .uart_out   (uart_out),
        .uart_wrreq (uart_wrreq),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_we    (imem_we),
        .core_run   (core_run),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // RX FIFO contents: a value >= 0 is a byte, -k means k empty cycles.
    int fifo[$];

    // Logs of what the DUT actually did.
    int unsigned wlog_addr[$];
    logic [31:0] wlog_data[$];
    logic [7:0]  tx_last;
    int          tx_cnt;

    // Model: mode 0 consuming, 1 ack cycle, 2 run, 3 first err cycle, 4 err held.
    int          m_mode, m_k, m_total;
    logic [31:0] m_n, m_word;
    logic [7:0]  m_xor;
    logic        e_we, e_wrreq, e_run, e_error;
    logic [31:0] e_addr, e_data;
    logic [7:0]  e_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_total = -1;
        m_n = 0; m_word = 0; m_xor = 0;
        e_we = 0; e_wrreq = 0; e_run = 0; e_error = 0;
        e_addr = 0; e_data = 0; e_out = 8'h00;
    endtask

    task automatic enter_ack();
        m_mode = 1; e_wrreq = 1; e_out = 8'hAA;
    endtask

    task automatic enter_err();
        m_mode = 3; e_wrreq = 1; e_out = 8'hEE;
    endtask

    task automatic model_step(input bit pop, input logic [7:0] b);
        int k;
        int p;
        e_we = 0;
        e_wrreq = 0;
        if (m_mode == 1) begin
            m_mode = 2; e_run = 1;
        end else if (m_mode == 3) begin
            m_mode = 4; e_error = 1;
        end else if (m_mode == 0 && pop) begin
            k = m_k;
            m_k++;
            if (k < 4) begin
                m_n[8*k +: 8] = b;
                if (k == 3) begin
                    if (m_n > MAX_WORDS) enter_err();
                    else begin
                        m_total = 4 + 4 * int'(m_n) + CS;
                        if (m_total == 4) enter_ack();
                    end
                end
            end else if (k < 4 + 4 * int'(m_n)) begin
                p = k - 4;
                m_word[8*(p%4) +: 8] = b;
                if (p % 4 == 3) begin
                    e_we = 1; e_addr = p / 4; e_data = m_word;
                end
                if (k + 1 == m_total) enter_ack();
            end else begin
                if (b == m_xor) enter_ack();
                else enter_err();
            end
            m_xor = m_xor ^ b;
        end
    endtask

    // One clock cycle: drive FIFO at negedge, compare, then advance at posedge.
    task automatic cycle();
        bit          dut_pop;
        bit          m_pop;
        logic [7:0]  b;
        @(negedge clk);
        if (fifo.size() == 0 || fifo[0] < 0) begin
            uart_empty = 1'b1;
            uart_in    = 8'h00;
        end else begin
            uart_empty = 1'b0;
            uart_in    = 8'(fifo[0]);
        end
        #1;
        m_pop = (m_mode == 0) && !uart_empty;
        if (!rst) begin
            chk("uart_rdreq", 32'(uart_rdreq), 32'(m_pop));
            chk("uart_wrreq", 32'(uart_wrreq), 32'(e_wrreq));
            chk("uart_out", 32'(uart_out), 32'(e_out));
            chk("imem_we", 32'(imem_we), 32'(e_we));
            if (e_we) begin
                chk("imem_addr", 32'(imem_addr), e_addr);
                chk("imem_data", imem_data, e_data);
            end
            chk("core_run", 32'(core_run), 32'(e_run));
            chk("busy", 32'(busy), 32'(m_mode == 0));
            chk("error", 32'(error), 32'(e_error));
            if (imem_we) begin
                wlog_addr.push_back(32'(imem_addr));
                wlog_data.push_back(imem_data);
            end
            if (uart_wrreq) begin
                tx_last = uart_out;
                tx_cnt++;
            end
        end
        dut_pop = uart_rdreq && !uart_empty;
        b = uart_in;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(m_pop, b);
        if (dut_pop) begin
            void'(fifo.pop_front());
        end else if (fifo.size() > 0 && fifo[0] < 0) begin
            fifo[0] = fifo[0] + 1;
            if (fifo[0] == 0) void'(fifo.pop_front());
        end
    endtask

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        tx_last = 8'h00;
        tx_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo.delete();
        cycle();
        cycle();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_image();
        bit done = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (m_mode == 2 || m_mode == 4) begin
                done = 1;
                break;
            end
        end
        chk("image_finished", 32'(done), 32'd1);
        repeat (3) cycle();
    endtask

    task automatic push_bytes(input int bytes[$]);
        foreach (bytes[i]) fifo.push_back(bytes[i]);
    endtask

    task automatic check_two_word();
        chk("n_writes", wlog_addr.size(), 32'd2);
        if (wlog_addr.size() == 2) begin
            chk("w0_addr", wlog_addr[0], 32'd0);
            chk("w0_data", wlog_data[0], 32'h12345678);
            chk("w1_addr", wlog_addr[1], 32'd1);
            chk("w1_data", wlog_data[1], 32'hDEADBEEF);
        end
        chk("tx_byte", 32'(tx_last), 32'hAA);
        chk("tx_count", tx_cnt, 32'd1);
        chk("core_run_end", 32'(core_run), 32'd1);
    endtask

    initial begin
        uart_empty = 1'b1;
        uart_in    = 8'h00;
        rst        = 1'b1;
        model_reset();
        clear_logs();
        do_reset();

        // Reset state, sampled just after the reset edge.
        #1;
        chk("rst_rdreq", 32'(uart_rdreq), 32'd0);
        chk("rst_wrreq", 32'(uart_wrreq), 32'd0);
        chk("rst_out", 32'(uart_out), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_data", imem_data, 32'd0);
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Two-word image, FIFO never empty.
        push_bytes('{8'h02, 0, 0, 0, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        if (CS == 1) fifo.push_back(8'h28);
        run_image();
        check_two_word();

        // Same image with a 5-cycle empty gap between b1 and b2.
        do_reset();
        push_bytes('{8'h02, 0, 0, 0, 8'h78, 8'h56, -5, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        if (CS == 1) fifo.push_back(8'h28);
        run_image();
        check_two_word();

        // Oversize header: N = MAX_WORDS + 1 = 0x4001.
        do_reset();
        push_bytes('{8'h01, 8'h40, 0, 0, 8'h11, 8'h22});
        run_image();
        chk("ovs_writes", wlog_addr.size(), 32'd0);
        chk("ovs_tx_byte", 32'(tx_last), 32'hEE);
        chk("ovs_tx_count", tx_cnt, 32'd1);
        chk("ovs_error", 32'(error), 32'd1);
        chk("ovs_core_run", 32'(core_run), 32'd0);
        chk("ovs_fifo_left", fifo.size(), 32'd2);

        // Zero-length image; a trailing 0x55 must stay in the FIFO.
        do_reset();
        push_bytes('{0, 0, 0, 0});
        if (CS == 1) fifo.push_back(8'h00);
        fifo.push_back(8'h55);
        run_image();
        chk("zero_writes", wlog_addr.size(), 32'd0);
        chk("zero_tx_byte", 32'(tx_last), 32'hAA);
        chk("zero_core_run", 32'(core_run), 32'd1);
        chk("zero_fifo_left", fifo.size(), 32'd1);

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum good (0x05) and bad (0x06).
        do_reset();
        push_bytes('{8'h01, 0, 0, 0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        run_image();
        chk("csum_ok_tx", 32'(tx_last), 32'hAA);
        chk("csum_ok_run", 32'(core_run), 32'd1);
        chk("csum_ok_writes", wlog_addr.size(), 32'd1);
        if (wlog_data.size() == 1) chk("csum_ok_data", wlog_data[0], 32'h04030201);
        do_reset();
        push_bytes('{8'h01, 0, 0, 0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06});
        run_image();
        chk("csum_bad_tx", 32'(tx_last), 32'hEE);
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_run", 32'(core_run), 32'd0);
`endif

        // Reset after 6 payload bytes, then a fresh one-word image.
        do_reset();
        push_bytes('{8'h02, 0, 0, 0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        begin
            bit reached = 0;
            for (int i = 0; i < 100; i++) begin
                cycle();
                if (m_k == 10) begin
                    reached = 1;
                    break;
                end
            end
            chk("midload_reached", 32'(reached), 32'd1);
        end
        do_reset();
        #1;
        chk("midload_core_run", 32'(core_run), 32'd0);
        chk("midload_busy", 32'(busy), 32'd1);
        push_bytes('{8'h01, 0, 0, 0, 8'h0D, 8'hF0, 8'hFE, 8'hCA});
        if (CS == 1) fifo.push_back(8'hC8);
        run_image();
        chk("reload_writes", wlog_addr.size(), 32'd1);
        if (wlog_addr.size() == 1) begin
            chk("reload_addr", wlog_addr[0], 32'd0);
            chk("reload_data", wlog_data[0], 32'hCAFEF00D);
        end
        chk("reload_tx", 32'(tx_last), 32'hAA);
        chk("reload_run", 32'(core_run), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
